// File: rtl/seven_seg_pkg.sv
// Shared constants, scan-phase encoding and anode decode for the
// multiplexed four-digit seven-segment scan controller.
package seven_seg_pkg;

  localparam int         NUM_DIGITS = 4;
  localparam logic [7:0] SEG_BLANK  = 8'hFF;
  localparam logic [3:0] ANODE_OFF  = 4'hF;
  localparam int         PWM_STEPS  = 16;

  typedef enum logic [1:0] {
    BLANK,
    ON,
    OFF
  } scan_state_t;

  function automatic logic [3:0] anode_decode(input logic [1:0] idx);
    anode_decode = ~(4'b0001 << idx);
  endfunction

endpackage

// File: rtl/seven_seg_tick_gen.sv
// PWM sub-tick prescaler: one-cycle tick every TICK_CYCLES enabled cycles,
// restarted on reset and at each slot boundary.
module seven_seg_tick_gen #(
  parameter int TICK_CYCLES = 2
) (
  input  logic clk,
  input  logic rst,
  input  logic clr,
  input  logic en,
  output logic tick
);

  localparam int            TW        = $clog2(TICK_CYCLES + 1);
  localparam logic [TW-1:0] TICK_LAST = TW'(TICK_CYCLES - 1);

  logic [TW-1:0] cnt;

  always_ff @(posedge clk) begin
    if (rst || clr) begin
      cnt <= '0;
    end else if (en) begin
      if (cnt == TICK_LAST) cnt <= '0;
      else                  cnt <= cnt + TW'(1);
    end
  end

  assign tick = en && (cnt == TICK_LAST);

endmodule

// File: rtl/seven_seg_scan_ctrl.sv
// Four-digit seven-segment scan scheduler: blank/on/off slot FSM with PWM
// brightness and a double-buffered pattern write port swapped at frame ends.
module seven_seg_scan_ctrl
  import seven_seg_pkg::*;
#(
  parameter int TICK_CYCLES  = 2,
  parameter int BLANK_CYCLES = 3
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        wr_valid,
  output logic        wr_ready,
  input  logic [31:0] wr_data,
  input  logic [3:0]  brightness,
  input  logic [3:0]  digit_en,
  output logic [7:0]  seg_out,
  output logic [3:0]  anode,
  output logic        frame_done
);

  localparam int            SLOT       = BLANK_CYCLES + PWM_STEPS * TICK_CYCLES;
  localparam int            SW         = $clog2(SLOT);
  localparam logic [SW-1:0] SLOT_LAST  = SW'(SLOT - 1);
  localparam logic [SW-1:0] BLANK_LAST = SW'(BLANK_CYCLES - 1);
  localparam logic [1:0]    DIGIT_LAST = 2'(NUM_DIGITS - 1);

  scan_state_t   state;
  logic [SW-1:0] slot_cnt;
  logic [1:0]    digit;
  logic [3:0]    pwm_cnt;
  logic [3:0]    bright_q;
  logic [3:0]    en_q;
  logic [31:0]   active;
  logic [31:0]   pending;
  logic          pending_valid;
  logic          tick;
  logic          slot_last;
  logic          wr_fire;

  assign slot_last = (slot_cnt == SLOT_LAST);
  assign wr_ready  = ~pending_valid & ~rst;
  assign wr_fire   = wr_valid & wr_ready;

  seven_seg_tick_gen #(
    .TICK_CYCLES(TICK_CYCLES)
  ) u_tick_gen (
    .clk (clk),
    .rst (rst),
    .clr (slot_last),
    .en  (state != BLANK),
    .tick(tick)
  );

  // Each edge emits the outputs for the slot cycle held in slot_cnt/state,
  // then advances those registers to the following cycle.
  always_ff @(posedge clk) begin
    if (rst) begin
      state         <= BLANK;
      slot_cnt      <= '0;
      digit         <= 2'd0;
      pwm_cnt       <= 4'd0;
      bright_q      <= 4'd0;
      en_q          <= 4'd0;
      active        <= 32'hFFFF_FFFF;
      pending_valid <= 1'b0;
      anode         <= ANODE_OFF;
      seg_out       <= SEG_BLANK;
      frame_done    <= 1'b0;
    end else begin
      anode      <= ANODE_OFF;
      seg_out    <= SEG_BLANK;
      frame_done <= 1'b0;

      if (slot_cnt == '0) begin
        bright_q <= brightness;
        en_q     <= digit_en;
      end

      slot_cnt <= slot_last ? '0 : slot_cnt + SW'(1);

      if (tick && pwm_cnt != 4'hF) pwm_cnt <= pwm_cnt + 4'd1;

      case (state)
        BLANK: begin
          if (slot_cnt == BLANK_LAST) begin
            state   <= ON;
            pwm_cnt <= 4'd0;
          end
        end
        ON: begin
          if (en_q[digit]) begin
            anode   <= anode_decode(digit);
            seg_out <= active[{digit, 3'b000} +: 8];
          end
          if (tick && pwm_cnt == bright_q && bright_q != 4'hF) state <= OFF;
        end
        OFF: begin
        end
        default: state <= BLANK;
      endcase

      if (slot_last) begin
        state      <= BLANK;
        pwm_cnt    <= 4'd0;
        digit      <= (digit == DIGIT_LAST) ? 2'd0 : digit + 2'd1;
        frame_done <= (digit == DIGIT_LAST);
      end

      // The swap lands on the edge that closes the frame_done cycle, so a
      // write accepted on that same edge waits for the next frame.
      if (frame_done && pending_valid) begin
        active        <= pending;
        pending_valid <= 1'b0;
      end

      if (wr_fire) pending_valid <= 1'b1;
    end
  end

  always_ff @(posedge clk) begin
    if (wr_fire) pending <= wr_data;
  end

endmodule

// File: tb/tb_seven_seg_scan_ctrl.sv
// Scoreboard bench: a slot-arithmetic reference model queues the expected
// outputs each cycle and a monitor compares them against the DUT.
module tb_seven_seg_scan_ctrl;

  localparam int TICK   = 2;
  localparam int BLANKC = 3;
  localparam int SLOT   = BLANKC + 16 * TICK;
  localparam int FRAME  = 4 * SLOT;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        wr_valid = 1'b0;
  logic [31:0] wr_data = 32'h0;
  logic [3:0]  brightness = 4'hF;
  logic [3:0]  digit_en = 4'hF;
  logic        wr_ready;
  logic [7:0]  seg_out;
  logic [3:0]  anode;
  logic        frame_done;

  seven_seg_scan_ctrl #(
    .TICK_CYCLES (TICK),
    .BLANK_CYCLES(BLANKC)
  ) dut (
    .clk       (clk),
    .rst       (rst),
    .wr_valid  (wr_valid),
    .wr_ready  (wr_ready),
    .wr_data   (wr_data),
    .brightness(brightness),
    .digit_en  (digit_en),
    .seg_out   (seg_out),
    .anode     (anode),
    .frame_done(frame_done)
  );

  always #5 clk = ~clk;

  typedef struct packed {
    logic [3:0] an;
    logic [7:0] seg;
    logic       fd;
    logic       rdy;
  } exp_t;

  exp_t exp_q[$];
  int   n_checks = 0;
  int   n_fail   = 0;
  int   cyc      = 0;

  int          t;
  logic [31:0] m_active;
  logic [31:0] m_pending;
  bit          m_pend_v;
  bit          m_prev_fd;
  int          m_bright;
  logic [3:0]  m_en;

  // Reference model: slot position from elapsed cycles since reset release.
  always @(posedge clk) begin : model
    exp_t e;
    int   c;
    int   d;
    bit   accept;
    if (rst) begin
      t         = 0;
      m_active  = 32'hFFFF_FFFF;
      m_pend_v  = 1'b0;
      m_prev_fd = 1'b0;
      m_bright  = 15;
      m_en      = 4'hF;
      e.an      = 4'hF;
      e.seg     = 8'hFF;
      e.fd      = 1'b0;
      e.rdy     = 1'b0;
    end else begin
      accept = wr_valid && !m_pend_v;
      if (m_prev_fd && m_pend_v) begin
        m_active = m_pending;
        m_pend_v = 1'b0;
      end
      if (accept) begin
        m_pending = wr_data;
        m_pend_v  = 1'b1;
      end
      c = t % SLOT;
      d = (t / SLOT) % 4;
      if (c == 0) begin
        m_bright = int'(brightness);
        m_en     = digit_en;
      end
      e.an  = 4'hF;
      e.seg = 8'hFF;
      if (c >= BLANKC && c < BLANKC + (m_bright + 1) * TICK && m_en[d]) begin
        e.an  = ~(4'b0001 << d);
        e.seg = m_active[8*d +: 8];
      end
      e.fd      = (c == SLOT - 1) && (d == 3);
      e.rdy     = !m_pend_v;
      m_prev_fd = e.fd;
      t++;
    end
    exp_q.push_back(e);
  end

  always @(negedge clk) begin : monitor
    exp_t e;
    cyc++;
    if (exp_q.size() > 0) begin
      e = exp_q.pop_front();
      n_checks++;
      if (anode !== e.an || seg_out !== e.seg || frame_done !== e.fd || wr_ready !== e.rdy) begin
        n_fail++;
        $display("FAIL outputs cycle %0d: got anode=%h seg=%h fd=%b rdy=%b, expected anode=%h seg=%h fd=%b rdy=%b",
                 cyc, anode, seg_out, frame_done, wr_ready, e.an, e.seg, e.fd, e.rdy);
      end
      n_checks++;
      if (!(anode inside {4'hF, 4'hE, 4'hD, 4'hB, 4'h7})) begin
        n_fail++;
        $display("FAIL anode_onehot cycle %0d: got %h, expected F/E/D/B/7", cyc, anode);
      end
    end
  end

  task automatic step(input int n = 1);
    repeat (n) begin
      @(negedge clk);
      #1;
    end
  endtask

  task automatic do_write(input logic [31:0] d);
    bit ok;
    ok       = 1'b0;
    wr_data  = d;
    wr_valid = 1'b1;
    for (int i = 0; i < 3 * FRAME; i++) begin
      ok = wr_ready;
      step();
      if (ok) break;
    end
    wr_valid = 1'b0;
    n_checks++;
    if (!ok) begin
      n_fail++;
      $display("FAIL write_timeout: got wr_ready=0 for %0d cycles, expected acceptance", 3 * FRAME);
    end
  endtask

  task automatic wait_fd();
    bit ok;
    ok = 1'b0;
    for (int i = 0; i < 2 * FRAME; i++) begin
      if (frame_done === 1'b1) begin
        ok = 1'b1;
        break;
      end
      step();
    end
    n_checks++;
    if (!ok) begin
      n_fail++;
      $display("FAIL frame_done_timeout: got no pulse, expected one within %0d cycles", 2 * FRAME);
    end
  endtask

  task automatic wait_anode(input logic [3:0] v);
    bit ok;
    ok = 1'b0;
    for (int i = 0; i < 2 * FRAME; i++) begin
      if (anode === v) begin
        ok = 1'b1;
        break;
      end
      step();
    end
    n_checks++;
    if (!ok) begin
      n_fail++;
      $display("FAIL anode_timeout: got anode=%h, expected %h within %0d cycles", anode, v, 2 * FRAME);
    end
  endtask

  initial begin
    rst = 1'b1;
    step(3);
    rst = 1'b0;

    // idle scan with defaults
    step(2 * FRAME);

    // single write mid-frame
    step(50);
    do_write(32'h1122_3344);
    step(2 * FRAME);

    // brightness extremes and mid-level
    brightness = 4'd0;
    step(FRAME + SLOT);
    brightness = 4'd7;
    step(FRAME + SLOT);

    // partial digit enable
    brightness = 4'hF;
    digit_en   = 4'b1010;
    step(2 * FRAME);
    digit_en   = 4'hF;

    // write on the boundary cycle, then a back-to-back second write
    wait_fd();
    do_write(32'hA1B2_C3D4);
    do_write(32'h5566_7788);
    step(2 * FRAME);

    // reset during digit 2 ON with a write pending
    wait_fd();
    step(2);
    do_write(32'hDEAD_BEEF);
    wait_anode(4'hB);
    rst = 1'b1;
    step(1);
    rst = 1'b0;
    step(2 * FRAME);

    // randomized traffic
    for (int k = 0; k < 40; k++) begin
      brightness = 4'($urandom_range(0, 15));
      digit_en   = 4'($urandom_range(0, 15));
      if ($urandom_range(0, 2) != 0) do_write($urandom());
      step($urandom_range(1, 200));
      if ($urandom_range(0, 9) == 0) begin
        rst = 1'b1;
        step($urandom_range(1, 3));
        rst = 1'b0;
      end
    end
    step(FRAME);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
